// File: rtl/mxv_frame_engine.sv
// mxv_frame_engine: byte-framed matrix x vector engine.
// Receives frames FE LEN CMD payload EF, keeps an N x N byte matrix and an
// N-byte vector, computes y = M*v one MAC per cycle and streams each y[i]
// back as ACC_BYTES bytes, MSB first.
// Optional build macro: MXV_SIGNED_EN (signed elements, sign-extended results;
// without it elements are unsigned and results are zero-extended).
// Ports:
//   clk, rst (async, active low)  clock / reset
//   start                         parser enable (parser held in IDLE while low)
//   Rx_flag, FIFO_input[7:0]      received byte strobe and data
//   tx_ready                      downstream accepts Data_Tx this cycle
//   flag_Tx, Data_Tx[7:0]         result byte valid / result byte
//   flag_RESEND                   pulse asking the host to resend the frame
//   busy                          high while computing or transmitting
module mxv_frame_engine #(
    parameter int MAX_N     = 8,
    parameter int DEFAULT_N = 4,
    parameter int ACC_BYTES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       Rx_flag,
    input  logic [7:0] FIFO_input,
    input  logic       tx_ready,
    output logic       flag_Tx,
    output logic       flag_RESEND,
    output logic [7:0] Data_Tx,
    output logic       busy
);
    localparam int NW = $clog2(MAX_N + 1);
    localparam int EW = $clog2(MAX_N);
    localparam int AW = 16 + $clog2(MAX_N);
    localparam int RW = ACC_BYTES * 8;
    localparam int MM = MAX_N * MAX_N;
    localparam int MI = $clog2(MM);
    localparam int BW = (ACC_BYTES > 1) ? $clog2(ACC_BYTES) : 1;
    localparam logic [8:0]    MM_LIM  = 9'(MM);
    localparam logic [7:0]    MAX_N_B = 8'(MAX_N);
    localparam logic [BW-1:0] LAST_B  = BW'(ACC_BYTES - 1);
    localparam logic [7:0] SOF_B = 8'hFE;
    localparam logic [7:0] EOF_B = 8'hEF;
    localparam logic [7:0] CMD_SET_N  = 8'h01;
    localparam logic [7:0] CMD_RESEND = 8'h02;
    localparam logic [7:0] CMD_LOAD_M = 8'h03;
    localparam logic [7:0] CMD_LOAD_V = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_CMD, S_PAYLOAD, S_EOF, S_COMPUTE, S_TX, S_ERR
    } state_t;

    state_t           state_r, state_nx_s;
    logic [NW-1:0]    n_r;
    logic             result_valid_r, flag_tx_r, err_pulse_r;
    logic [7:0]       data_tx_r, len_r, cmd_r, pcnt_r;
    logic [EW-1:0]    row_r, col_r, eidx_r, nm1_s;
    logic [MI-1:0]    k_r;
    logic [BW-1:0]    bidx_r;
    logic [AW-1:0]    acc_r, prod_s, sum_s;
    logic [7:0]       buf_r [MM];
    logic [7:0]       mat_r [MM];
    logic [7:0]       vec_r [MAX_N];
    logic [RW-1:0]    res_r [MAX_N];
    logic [RW-1:0]    first_res_s;
    logic [15:0]      n16_s, nn_s;
    logic [7:0]       mac_a_s, mac_b_s;
    logic             cmd_ok_s, setn_bad_s, go_err_s, commit_s, go_tx_s;
    logic             last_mac_s, last_byte_s, accept_s, busy_s;

    // Fit an accumulator value into the transmitted result width.
    function automatic logic [RW-1:0] to_res(input logic [AW-1:0] s);
        logic [AW+RW-1:0] w;
`ifdef MXV_SIGNED_EN
        w = {{RW{s[AW-1]}}, s};
`else
        w = {{RW{1'b0}}, s};
`endif
        return w[RW-1:0];
    endfunction

    // Byte b of a result, b=0 being the most significant byte.
    function automatic logic [7:0] byte_of(input logic [RW-1:0] v, input logic [BW-1:0] b);
        return v[(ACC_BYTES - 1 - int'(b)) * 8 +: 8];
    endfunction

    assign nm1_s      = EW'(n_r - NW'(1));
    assign n16_s      = 16'(n_r);
    assign nn_s       = n16_s * n16_s;
    assign setn_bad_s = (FIFO_input == 8'd0) || (FIFO_input > MAX_N_B);
    assign mac_a_s    = mat_r[k_r];
    assign mac_b_s    = vec_r[col_r];

`ifdef MXV_SIGNED_EN
    logic signed [15:0] prod16_s;
    assign prod16_s = 16'($signed(mac_a_s)) * 16'($signed(mac_b_s));
    assign prod_s   = {{(AW-16){prod16_s[15]}}, prod16_s};
`else
    logic [15:0] prod16_s;
    assign prod16_s = 16'(mac_a_s) * 16'(mac_b_s);
    assign prod_s   = {{(AW-16){1'b0}}, prod16_s};
`endif

    // A new row restarts the accumulator from zero instead of clearing it separately.
    assign sum_s       = ((col_r == {EW{1'b0}}) ? {AW{1'b0}} : acc_r) + prod_s;
    assign last_mac_s  = (row_r == nm1_s) && (col_r == nm1_s);
    assign last_byte_s = (eidx_r == nm1_s) && (bidx_r == LAST_B);
    assign accept_s    = flag_tx_r && tx_ready;
    assign busy_s      = (state_r == S_COMPUTE) || (state_r == S_TX);
    // With N=1 the only result is still being written on the last MAC edge.
    assign first_res_s = (nm1_s == {EW{1'b0}}) ? to_res(sum_s) : res_r[0];

    assign flag_Tx     = flag_tx_r;
    assign Data_Tx     = data_tx_r;
    assign busy        = busy_s;
    assign flag_RESEND = err_pulse_r || (busy_s && Rx_flag);

    // Command / length agreement check on the CMD byte.
    always_comb begin
        case (FIFO_input)
            CMD_SET_N:  cmd_ok_s = (len_r == 8'd1);
            CMD_RESEND: cmd_ok_s = (len_r == 8'd0);
            CMD_LOAD_M: cmd_ok_s = ({8'd0, len_r} == nn_s);
            CMD_LOAD_V: cmd_ok_s = ({8'd0, len_r} == n16_s);
            default:    cmd_ok_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= S_IDLE;
        else      state_r <= state_nx_s;
    end

    // Next-state logic and control strobes.
    always_comb begin
        state_nx_s = state_r;
        go_err_s   = 1'b0;
        commit_s   = 1'b0;
        go_tx_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && Rx_flag && (FIFO_input == SOF_B)) state_nx_s = S_LEN;
                else                                           state_nx_s = S_IDLE;
            end
            S_LEN: begin
                if (!start)       state_nx_s = S_IDLE;
                else if (Rx_flag) state_nx_s = S_CMD;
                else              state_nx_s = S_LEN;
            end
            S_CMD: begin
                if (!start) state_nx_s = S_IDLE;
                else if (Rx_flag) begin
                    if (!cmd_ok_s) begin
                        go_err_s   = 1'b1;
                        state_nx_s = S_ERR;
                    end else if (len_r == 8'd0) state_nx_s = S_EOF;
                    else                        state_nx_s = S_PAYLOAD;
                end else state_nx_s = S_CMD;
            end
            S_PAYLOAD: begin
                if (!start) state_nx_s = S_IDLE;
                else if (Rx_flag) begin
                    if ((cmd_r == CMD_SET_N) && setn_bad_s) begin
                        go_err_s   = 1'b1;
                        state_nx_s = S_ERR;
                    end else if (pcnt_r == (len_r - 8'd1)) state_nx_s = S_EOF;
                    else                                   state_nx_s = S_PAYLOAD;
                end else state_nx_s = S_PAYLOAD;
            end
            S_EOF: begin
                if (!start) state_nx_s = S_IDLE;
                else if (Rx_flag) begin
                    if (FIFO_input != EOF_B) begin
                        go_err_s   = 1'b1;
                        state_nx_s = S_ERR;
                    end else begin
                        case (cmd_r)
                            CMD_LOAD_V: begin
                                commit_s   = 1'b1;
                                state_nx_s = S_COMPUTE;
                            end
                            CMD_RESEND: begin
                                if (result_valid_r) begin
                                    go_tx_s    = 1'b1;
                                    state_nx_s = S_TX;
                                end else begin
                                    go_err_s   = 1'b1;
                                    state_nx_s = S_ERR;
                                end
                            end
                            default: begin
                                commit_s   = 1'b1;
                                state_nx_s = S_IDLE;
                            end
                        endcase
                    end
                end else state_nx_s = S_EOF;
            end
            S_COMPUTE: begin
                if (last_mac_s) state_nx_s = S_TX;
                else            state_nx_s = S_COMPUTE;
            end
            S_TX: begin
                if (accept_s && last_byte_s) state_nx_s = S_IDLE;
                else                         state_nx_s = S_TX;
            end
            S_ERR:   state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Control registers: frame fields, N, MAC counters and the TX byte stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_r            <= NW'(DEFAULT_N);
            result_valid_r <= 1'b0;
            flag_tx_r      <= 1'b0;
            data_tx_r      <= 8'h00;
            err_pulse_r    <= 1'b0;
            len_r          <= 8'd0;
            cmd_r          <= 8'd0;
            pcnt_r         <= 8'd0;
            row_r          <= {EW{1'b0}};
            col_r          <= {EW{1'b0}};
            eidx_r         <= {EW{1'b0}};
            bidx_r         <= {BW{1'b0}};
            k_r            <= {MI{1'b0}};
            acc_r          <= {AW{1'b0}};
        end else begin
            err_pulse_r <= go_err_s;
            case (state_r)
                S_LEN: if (Rx_flag) len_r <= FIFO_input;
                S_CMD: begin
                    if (Rx_flag) begin
                        cmd_r  <= FIFO_input;
                        pcnt_r <= 8'd0;
                    end
                end
                S_PAYLOAD: if (Rx_flag) pcnt_r <= pcnt_r + 8'd1;
                S_EOF: begin
                    if (commit_s && (cmd_r == CMD_SET_N)) n_r <= buf_r[0][NW-1:0];
                    if (commit_s && (cmd_r == CMD_LOAD_V)) begin
                        row_r          <= {EW{1'b0}};
                        col_r          <= {EW{1'b0}};
                        k_r            <= {MI{1'b0}};
                        result_valid_r <= 1'b0;
                    end
                    if (go_tx_s) begin
                        flag_tx_r <= 1'b1;
                        data_tx_r <= byte_of(res_r[0], {BW{1'b0}});
                        eidx_r    <= {EW{1'b0}};
                        bidx_r    <= {BW{1'b0}};
                    end
                end
                S_COMPUTE: begin
                    acc_r <= sum_s;
                    k_r   <= k_r + MI'(1);
                    if (col_r == nm1_s) begin
                        col_r <= {EW{1'b0}};
                        row_r <= row_r + EW'(1);
                    end else begin
                        col_r <= col_r + EW'(1);
                    end
                    if (last_mac_s) begin
                        flag_tx_r <= 1'b1;
                        data_tx_r <= byte_of(first_res_s, {BW{1'b0}});
                        eidx_r    <= {EW{1'b0}};
                        bidx_r    <= {BW{1'b0}};
                    end
                end
                S_TX: begin
                    if (accept_s) begin
                        if (last_byte_s) begin
                            flag_tx_r      <= 1'b0;
                            result_valid_r <= 1'b1;
                        end else if (bidx_r == LAST_B) begin
                            eidx_r    <= eidx_r + EW'(1);
                            bidx_r    <= {BW{1'b0}};
                            data_tx_r <= byte_of(res_r[eidx_r + EW'(1)], {BW{1'b0}});
                        end else begin
                            bidx_r    <= bidx_r + BW'(1);
                            data_tx_r <= byte_of(res_r[eidx_r], bidx_r + BW'(1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload staging, commit on a valid EOF, and result capture (not reset).
    always_ff @(posedge clk) begin
        if ((state_r == S_PAYLOAD) && start && Rx_flag && ({1'b0, pcnt_r} < MM_LIM))
            buf_r[pcnt_r[MI-1:0]] <= FIFO_input;
        if (commit_s && (cmd_r == CMD_LOAD_M))
            for (int x = 0; x < MM; x++) mat_r[x] <= buf_r[x];
        if (commit_s && (cmd_r == CMD_LOAD_V))
            for (int x = 0; x < MAX_N; x++) vec_r[x] <= buf_r[x];
        if ((state_r == S_COMPUTE) && (col_r == nm1_s))
            res_r[row_r] <= to_res(sum_s);
    end

endmodule
